// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout and endpoint-port FSM encoding.
package noc_pkg;

  localparam int unsigned FLIT_W     = 20;
  localparam int unsigned DEST_CL_HI = 19;
  localparam int unsigned DEST_CL_LO = 18;
  localparam int unsigned DEST_LO_HI = 17;
  localparam int unsigned DEST_LO_LO = 16;
  localparam int unsigned PAYLOAD_HI = 15;
  localparam int unsigned PAYLOAD_LO = 0;
  localparam int unsigned PAYLOAD_W  = PAYLOAD_HI - PAYLOAD_LO + 1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StSend  = 2'd1,
    StStall = 2'd2
  } ep_state_e;

  // Endpoint state is a pure function of queue occupancy and credit availability.
  function automatic ep_state_e ep_next_state(input logic fifo_nonempty,
                                              input logic have_credit);
    if (!fifo_nonempty) begin
      return StIdle;
    end
    return have_credit ? StSend : StStall;
  endfunction

endpackage

// File: rtl/pe_tx_fifo.sv
// Synchronous TX FIFO for the PE endpoint port; pushes into a full FIFO are dropped.
module pe_tx_fifo #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] head,
  output logic            full,
  output logic [CntW-1:0] count_next
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_acc, pop_acc;

  assign full     = (count_q == CntW'(DEPTH));
  assign push_acc = push && !full;
  assign pop_acc  = pop && (count_q != '0);
  assign head     = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push_acc && !pop_acc) begin
      count_d = count_q + CntW'(1);
    end else if (pop_acc && !push_acc) begin
      count_d = count_q - CntW'(1);
    end
  end

  // Post-edge occupancy, used by the owner to pick its next state.
  assign count_next = count_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_acc) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop_acc) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pe_endpoint_port.sv
// PE-side router local port: credit-based TX injection and unconditional RX ejection.
// Optional destination check on RX enabled by defining PE_RX_DEST_CHECK_EN (adds rx_err).
module pe_endpoint_port #(
  parameter int unsigned FLIT_W     = noc_pkg::FLIT_W,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned CREDITS    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        my_cluster,
  input  logic [1:0]        my_local,
  input  logic              tx_push,
  input  logic [FLIT_W-1:0] tx_flit,
  output logic              tx_full,
  output logic [FLIT_W-1:0] dataout,
  output logic              out_valid,
  input  logic              ci,
  input  logic [FLIT_W-1:0] datain,
  input  logic              in_valid,
  output logic [15:0]       read,
  output logic [15:0]       rx_count,
  output logic              state,
  output logic              credit_err
`ifdef PE_RX_DEST_CHECK_EN
  ,
  output logic              rx_err
`endif
);

  import noc_pkg::*;

  localparam int unsigned CreditW = $clog2(CREDITS + 1);
  localparam int unsigned CntW    = $clog2(FIFO_DEPTH + 1);
  localparam logic [CreditW-1:0] CreditMax = CreditW'(CREDITS);

  ep_state_e             fsm_q, fsm_d;
  logic [CreditW-1:0]    credits_q, credits_d;
  logic                  credit_err_q, credit_err_d;
  logic [FLIT_W-1:0]     dataout_q, dataout_d;
  logic                  out_valid_q, out_valid_d;
  logic                  state_q, state_d;
  logic                  send;
  logic [FLIT_W-1:0]     fifo_head;
  logic [CntW-1:0]       fifo_count_next;
  logic [PAYLOAD_W-1:0]  read_q;
  logic [15:0]           rx_count_q;

  pe_tx_fifo #(
    .WIDTH (FLIT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (tx_push),
    .pop        (send),
    .wdata      (tx_flit),
    .head       (fifo_head),
    .full       (tx_full),
    .count_next (fifo_count_next)
  );

  // A send and a returned credit in the same cycle cancel out.
  always_comb begin
    credits_d    = credits_q;
    credit_err_d = credit_err_q;
    unique case ({send, ci})
      2'b10: credits_d = credits_q - CreditW'(1);
      2'b01: begin
        if (credits_q == CreditMax) begin
          credit_err_d = 1'b1;
        end else begin
          credits_d = credits_q + CreditW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q <= StIdle;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d = ep_next_state(fifo_count_next != '0, credits_d != '0);
  end

  always_comb begin
    send        = (fsm_q == StSend);
    out_valid_d = send;
    dataout_d   = send ? fifo_head : dataout_q;
    state_d     = (fsm_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credits_q    <= CreditMax;
      credit_err_q <= 1'b0;
      dataout_q    <= '0;
      out_valid_q  <= 1'b0;
      state_q      <= 1'b0;
    end else begin
      credits_q    <= credits_d;
      credit_err_q <= credit_err_d;
      dataout_q    <= dataout_d;
      out_valid_q  <= out_valid_d;
      state_q      <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_q     <= '0;
      rx_count_q <= '0;
    end else if (in_valid) begin
      read_q     <= datain[PAYLOAD_HI:PAYLOAD_LO];
      rx_count_q <= rx_count_q + 16'd1;
    end
  end

`ifdef PE_RX_DEST_CHECK_EN
  logic rx_err_q;
  logic dest_mismatch;

  // Misrouted flits are still latched and counted; only the flag records them.
  assign dest_mismatch = in_valid && (datain[DEST_CL_HI:DEST_LO_LO] != {my_cluster, my_local});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_err_q <= 1'b0;
    end else if (dest_mismatch) begin
      rx_err_q <= 1'b1;
    end
  end

  assign rx_err = rx_err_q;
`else
  logic unused_dest;
  assign unused_dest = ^{my_cluster, my_local, datain[DEST_CL_HI:DEST_LO_LO]};
`endif

  assign dataout    = dataout_q;
  assign out_valid  = out_valid_q;
  assign state      = state_q;
  assign credit_err = credit_err_q;
  assign read       = read_q;
  assign rx_count   = rx_count_q;

endmodule

// File: tb/tb_pe_endpoint_port.sv
// Self-checking bench for pe_endpoint_port: queue-based reference model plus directed checks.
module tb_pe_endpoint_port;

  localparam int unsigned FlitW   = 20;
  localparam int unsigned Depth   = 4;
  localparam int          Credits = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       my_cluster = 2'd1;
  logic [1:0]       my_local = 2'd2;
  logic             tx_push = 1'b0;
  logic [FlitW-1:0] tx_flit = '0;
  logic             tx_full;
  logic [FlitW-1:0] dataout;
  logic             out_valid;
  logic             ci = 1'b0;
  logic [FlitW-1:0] datain = '0;
  logic             in_valid = 1'b0;
  logic [15:0]      read;
  logic [15:0]      rx_count;
  logic             state;
  logic             credit_err;
`ifdef PE_RX_DEST_CHECK_EN
  logic             rx_err;
`endif

  always #5 clk = ~clk;

  pe_endpoint_port #(
    .FLIT_W     (FlitW),
    .FIFO_DEPTH (Depth),
    .CREDITS    (Credits)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .my_cluster (my_cluster),
    .my_local   (my_local),
    .tx_push    (tx_push),
    .tx_flit    (tx_flit),
    .tx_full    (tx_full),
    .dataout    (dataout),
    .out_valid  (out_valid),
    .ci         (ci),
    .datain     (datain),
    .in_valid   (in_valid),
    .read       (read),
    .rx_count   (rx_count),
    .state      (state),
    .credit_err (credit_err)
`ifdef PE_RX_DEST_CHECK_EN
    ,
    .rx_err     (rx_err)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of pending flits and an integer credit pool.
  logic [FlitW-1:0] m_q[$];
  int               m_cred = Credits;
  bit               m_err = 1'b0;
  logic [FlitW-1:0] m_dout = '0;
  bit               m_vld = 1'b0;
  logic [15:0]      m_read = '0;
  logic [15:0]      m_cnt = '0;
  bit               m_state = 1'b0;
  bit               m_rxerr = 1'b0;
  bit               m_snd;
  int               m_pre;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_q.delete();
      m_cred = Credits;
      m_err = 1'b0;
      m_dout = '0;
      m_vld = 1'b0;
      m_read = '0;
      m_cnt = '0;
      m_state = 1'b0;
      m_rxerr = 1'b0;
    end else begin
      m_pre = m_q.size();
      m_snd = (m_pre > 0) && (m_cred > 0);
      if (m_snd) m_dout = m_q.pop_front();
      m_vld = m_snd;
      if (tx_push && m_pre < int'(Depth)) m_q.push_back(tx_flit);
      if (ci && !m_snd) begin
        if (m_cred == Credits) m_err = 1'b1;
        else m_cred++;
      end else if (m_snd && !ci) begin
        m_cred--;
      end
      if (in_valid) begin
        m_read = datain[15:0];
        m_cnt++;
        if (datain[19:16] != {my_cluster, my_local}) m_rxerr = 1'b1;
      end
      m_state = (m_q.size() > 0);
    end
  end

  always @(negedge clk) begin
    chk("cmp_dataout", 32'(dataout), 32'(m_dout));
    chk("cmp_out_valid", 32'(out_valid), 32'(m_vld));
    chk("cmp_tx_full", 32'(tx_full), 32'(m_q.size() == int'(Depth)));
    chk("cmp_state", 32'(state), 32'(m_state));
    chk("cmp_credit_err", 32'(credit_err), 32'(m_err));
    chk("cmp_read", 32'(read), 32'(m_read));
    chk("cmp_rx_count", 32'(rx_count), 32'(m_cnt));
`ifdef PE_RX_DEST_CHECK_EN
    chk("cmp_rx_err", 32'(rx_err), 32'(m_rxerr));
`endif
  end

  // Observed injections, for the directed checks.
  int               sent_cnt = 0;
  logic [FlitW-1:0] drain_log[$];

  always @(posedge clk) begin
    #1;
    if (rst && out_valid) begin
      sent_cnt++;
      drain_log.push_back(dataout);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic ci_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      ci = 1'b1;
      tick();
      ci = 1'b0;
      tick();
      tick();
    end
  endtask

  task automatic push_seq(input logic [FlitW-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      tx_push = 1'b1;
      tx_flit = base + FlitW'(i);
      tick();
    end
    tx_push = 1'b0;
  endtask

  int base;

  initial begin
    #1 rst = 1'b0;
    tick();
    tick();
    chk("rst_dataout", 32'(dataout), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_tx_full", 32'(tx_full), 32'h0);
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_rx_count", 32'(rx_count), 32'h0);
    rst = 1'b1;
    tick();

    // Single flit into an idle port.
    tx_push = 1'b1;
    tx_flit = 20'h51234;
    tick();
    tx_push = 1'b0;
    chk("t1_state_hi", 32'(state), 32'h1);
    chk("t1_valid_lo", 32'(out_valid), 32'h0);
    tick();
    chk("t1_valid_hi", 32'(out_valid), 32'h1);
    chk("t1_dataout", 32'(dataout), 32'h51234);
    chk("t1_state_lo", 32'(state), 32'h0);
    tick();
    chk("t1_valid_drop", 32'(out_valid), 32'h0);
    chk("t1_dataout_hold", 32'(dataout), 32'h51234);
    ci_pulses(1);

    // Six flits, no credits returned: four go, then stall.
    base = sent_cnt;
    push_seq(20'hA0000, 6);
    repeat (4) tick();
    chk("t2_sent4", 32'(sent_cnt - base), 32'd4);
    chk("t2_state_stall", 32'(state), 32'h1);
    ci = 1'b1;
    tick();
    ci = 1'b0;
    chk("t2_valid_wait", 32'(out_valid), 32'h0);
    tick();
    chk("t2_valid5", 32'(out_valid), 32'h1);
    chk("t2_dataout5", 32'(dataout), 32'hA0004);
    tick();

    // Fill the FIFO while stalled, then push while full.
    push_seq(20'hB0000, 3);
    chk("t3_full", 32'(tx_full), 32'h1);
    tx_push = 1'b1;
    tx_flit = 20'hFFFFF;
    tick();
    tx_push = 1'b0;
    chk("t3_full_hold", 32'(tx_full), 32'h1);
    drain_log.delete();
    ci_pulses(8);
    chk("t3_drain_len", 32'(drain_log.size()), 32'd4);
    if (drain_log.size() == 4) begin
      chk("t3_drain0", 32'(drain_log[0]), 32'hA0005);
      chk("t3_drain1", 32'(drain_log[1]), 32'hB0000);
      chk("t3_drain2", 32'(drain_log[2]), 32'hB0001);
      chk("t3_drain3", 32'(drain_log[3]), 32'hB0002);
    end
    chk("t3_empty_state", 32'(state), 32'h0);

    // Send and credit return in the same cycle at two credits.
    base = sent_cnt;
    push_seq(20'hC0000, 2);
    repeat (3) tick();
    tx_push = 1'b1;
    tx_flit = 20'hC0002;
    tick();
    tx_push = 1'b0;
    ci = 1'b1;
    tick();
    ci = 1'b0;
    tick();
    push_seq(20'hD0000, 3);
    repeat (4) tick();
    chk("t4_sent5", 32'(sent_cnt - base), 32'd5);
    chk("t4_state_stall", 32'(state), 32'h1);
    ci_pulses(5);

    // Surplus credit while idle at full count.
    chk("t5_cerr_clear", 32'(credit_err), 32'h0);
    ci = 1'b1;
    tick();
    ci = 1'b0;
    chk("t5_cerr_set", 32'(credit_err), 32'h1);
    repeat (3) tick();
    chk("t5_cerr_sticky", 32'(credit_err), 32'h1);

    // RX path.
    in_valid = 1'b1;
    datain = 20'h6ABCD;
    tick();
    in_valid = 1'b0;
    chk("t6_read", 32'(read), 32'hABCD);
    chk("t6_count1", 32'(rx_count), 32'd1);
`ifdef PE_RX_DEST_CHECK_EN
    chk("t6_rx_err_ok", 32'(rx_err), 32'h0);
`endif
    in_valid = 1'b1;
    datain = 20'h70001;
    tick();
    in_valid = 1'b0;
    chk("t6_read_mis", 32'(read), 32'h0001);
    chk("t6_count2", 32'(rx_count), 32'd2);
`ifdef PE_RX_DEST_CHECK_EN
    chk("t6_rx_err_set", 32'(rx_err), 32'h1);
`endif
    in_valid = 1'b1;
    datain = 20'h60055;
    repeat (65533) tick();
    chk("t6_count_ffff", 32'(rx_count), 32'hFFFF);
    tick();
    in_valid = 1'b0;
    chk("t6_count_wrap", 32'(rx_count), 32'h0000);
    chk("t6_read_last", 32'(read), 32'h0055);

    // Asynchronous reset with three flits queued and no credits.
    push_seq(20'hE0000, 7);
    #2 rst = 1'b0;
    #1;
    chk("t7_rst_dataout", 32'(dataout), 32'h0);
    chk("t7_rst_valid", 32'(out_valid), 32'h0);
    chk("t7_rst_state", 32'(state), 32'h0);
    chk("t7_rst_cerr", 32'(credit_err), 32'h0);
    chk("t7_rst_read", 32'(read), 32'h0);
    chk("t7_rst_count", 32'(rx_count), 32'h0);
    tick();
    rst = 1'b1;
    base = sent_cnt;
    repeat (6) tick();
    chk("t7_no_stale", 32'(sent_cnt - base), 32'd0);
    push_seq(20'hF0000, 5);
    repeat (4) tick();
    chk("t7_credits4", 32'(sent_cnt - base), 32'd4);
    chk("t7_state_stall", 32'(state), 32'h1);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
